rom_bank_arbiter: RTL and testbench
===================================

ROM_BANK_ARBITER -- requirements
Module: rom_bank_arbiter

Interface
REQ-001 Parameter RESET_BANK, default 0, 2-bit bank selected after reset.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_valid  input  1  CPU bus cycle active this clock.
REQ-005 cpu_addr  input  13  CPU address; bit 12 = cartridge select.
REQ-006 cpu_rdata  output  8  registered cartridge read data.
REQ-007 cpu_rvalid  output  1  one-cycle strobe, cpu_rdata valid.
REQ-008 dbg_req  input  1  debug read request, four-phase level handshake.
REQ-009 dbg_addr  input  14  debug address; [13:12] = macro, [11:0] = offset.
REQ-010 dbg_ack  output  1  debug data valid; held until dbg_req low.
REQ-011 dbg_data  output  8  registered debug read data.
REQ-012 bank  output  2  current CPU bank register.
REQ-013 rom_addr0..rom_addr3  output  12 each  address to ROM macro 0..3.
REQ-014 rom_q0..rom_q3  input  8 each  combinational data from ROM macro 0..3.

Function
REQ-015 Cart access = cpu_valid && cpu_addr[12]; SHALL drive rom_addr[bank] = cpu_addr[11:0] combinationally in that cycle.
REQ-016 Cart access SHALL load cpu_rdata from rom_q[bank] at the next edge and pulse cpu_rvalid for exactly one cycle (latency 1); non-cart cycles leave cpu_rdata unchanged, cpu_rvalid 0.
REQ-017 Cart access with cpu_addr[11:0] in 0xFF6..0xFF9 SHALL set bank = cpu_addr[11:0] - 0xFF6 at that edge; data returned for that access comes from the old bank.
REQ-018 ROM address ports not driven by CPU or debug in a cycle SHALL be 12'h000.
REQ-019 Debug FSM states: IDLE, WAIT, READ, DONE.
REQ-020 IDLE: dbg_req=1 captures dbg_addr into an internal register, -> WAIT.
REQ-021 WAIT: if no cart access, or captured macro != bank, SHALL drive rom_addr[captured macro] = captured offset, -> READ; else stay WAIT.
REQ-022 READ: dbg_data loaded from the macro read in the WAIT grant cycle (registered at the grant edge), -> DONE.
REQ-023 DONE: dbg_ack=1; dbg_req=0 -> IDLE (dbg_ack 0 next cycle); dbg_data stable throughout DONE.
REQ-024 CPU SHALL never be stalled or delayed by debug activity; conflicts always resolved in CPU favour.
REQ-025 Debug access SHALL NOT trigger bank switching, even at hotspot offsets.
REQ-026 Hotspot and debug grant in same cycle: conflict check uses pre-switch bank.
REQ-027 dbg_req dropping in WAIT or READ SHALL NOT abort; transaction completes, then DONE exits on next cycle with dbg_req low.

Reset
REQ-028 rst_n low SHALL asynchronously force bank=RESET_BANK, cpu_rdata=0, cpu_rvalid=0, dbg_data=0, dbg_ack=0, FSM=IDLE.
REQ-029 Reset mid-transaction SHALL abandon it with no dbg_ack pulse; a fresh request is needed after release.

Configuration
REQ-030 Macro BANK_SWITCH_EN defined: hotspot switching per REQ-017.
REQ-031 BANK_SWITCH_EN undefined: bank fixed at RESET_BANK, hotspot offsets read as ordinary data, bank output constant.

Verification
REQ-032 Reset, cart read 0x1000 with rom_q0=0xA5 -> rom_addr0=0x000, cpu_rdata=0xA5, cpu_rvalid one cycle after.
REQ-033 Cart read 0x1FF8 -> data from bank 0, bank=2 next cycle; read 0x1010 -> rom_addr2=0x010, other ports 0.
REQ-034 bank=1, debug 0x1234 while CPU streams cart reads -> stays WAIT; first idle CPU cycle grants, rom_addr1=0x234, dbg_ack after 2 cycles.
REQ-035 bank=0, debug 0x3ABC with continuous cart reads -> granted immediately, rom_addr3=0xABC in parallel, no cpu_rvalid gap.
REQ-036 dbg_req held high after dbg_ack -> dbg_ack stays 1, no second read; drop -> IDLE next cycle.
REQ-037 BANK_SWITCH_EN undefined, RESET_BANK=3, read 0x1FF6 -> bank stays 3, data = rom_q3 at 0xFF6.

Source files
------------

// File: rtl/rom_bank_arbiter.sv
// rom_bank_arbiter: cartridge ROM bank mapper sharing four macros with a debug reader.
// Define BANK_SWITCH_EN to enable hotspot bank switching at offsets 0xFF6..0xFF9.
module rom_bank_arbiter #(
    parameter logic [1:0] RESET_BANK = 2'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    input  logic [12:0] cpu_addr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        dbg_req,
    input  logic [13:0] dbg_addr,
    output logic        dbg_ack,
    output logic [7:0]  dbg_data,
    output logic [1:0]  bank,
    output logic [11:0] rom_addr0,
    output logic [11:0] rom_addr1,
    output logic [11:0] rom_addr2,
    output logic [11:0] rom_addr3,
    input  logic [7:0]  rom_q0,
    input  logic [7:0]  rom_q1,
    input  logic [7:0]  rom_q2,
    input  logic [7:0]  rom_q3
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DONE
    } dbg_state_t;

    dbg_state_t  state;
    logic [13:0] dbg_addr_q;
    logic [1:0]  dbg_macro;
    logic [11:0] dbg_off;
    logic        cart;
    logic        grant;
    logic [7:0]  q_mux    [4];
    logic [11:0] addr_mux [4];

    assign q_mux[0] = rom_q0;
    assign q_mux[1] = rom_q1;
    assign q_mux[2] = rom_q2;
    assign q_mux[3] = rom_q3;

    assign cart      = cpu_valid & cpu_addr[12];
    assign dbg_macro = dbg_addr_q[13:12];
    assign dbg_off   = dbg_addr_q[11:0];

    // The CPU owns its bank macro; debug only uses a macro the CPU leaves idle.
    assign grant = (state == S_WAIT) &&
                   (!cart || (dbg_macro != bank));

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_mux[i] = 12'h000;
        end
        if (cart) begin
            addr_mux[bank] = cpu_addr[11:0];
        end
        if (grant) begin
            addr_mux[dbg_macro] = dbg_off;
        end
    end

    assign rom_addr0 = addr_mux[0];
    assign rom_addr1 = addr_mux[1];
    assign rom_addr2 = addr_mux[2];
    assign rom_addr3 = addr_mux[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata  <= 8'h00;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cart;
            if (cart) begin
                cpu_rdata <= q_mux[bank];
            end
        end
    end

`ifdef BANK_SWITCH_EN
    logic       hot;
    logic [1:0] hot_bank;

    assign hot = cart &&
                 (cpu_addr[11:0] >= 12'hFF6) &&
                 (cpu_addr[11:0] <= 12'hFF9);

    // 0xFF6..0xFF9 map to banks 0..3 by the two low address bits.
    assign hot_bank = cpu_addr[1:0] + 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= RESET_BANK;
        end else if (hot) begin
            bank <= hot_bank;
        end
    end
`else
    assign bank = RESET_BANK;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dbg_addr_q <= 14'h0000;
            dbg_data   <= 8'h00;
            dbg_ack    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (dbg_req) begin
                        dbg_addr_q <= dbg_addr;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (grant) begin
                        dbg_data <= q_mux[dbg_macro];
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    dbg_ack <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (!dbg_req) begin
                        dbg_ack <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bank_arbiter.sv
// tb_rom_bank_arbiter: scoreboard bench for rom_bank_arbiter.
// Adapts its bank model to whether BANK_SWITCH_EN is defined.
module tb_rom_bank_arbiter;

    localparam logic [1:0] RB = 2'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        dbg_req;
    logic [13:0] dbg_addr;
    logic        dbg_ack;
    logic [7:0]  dbg_data;
    logic [1:0]  bank;
    logic [11:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3;
    logic [7:0]  rom_q0, rom_q1, rom_q2, rom_q3;

    int checks = 0;
    int errors = 0;

    logic [7:0] exq [$];
    logic [1:0] mb      = RB;
    logic [1:0] sw_bank = RB;
    logic       sw_pend = 1'b0;
    logic [7:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    function automatic logic [7:0] romf(input logic [1:0] m,
                                        input logic [11:0] a);
        logic [7:0] k;
        k = 8'hA5 + ({6'd0, m} * 8'h3C);
        return a[7:0] ^ {a[11:8], 4'h0} ^ k;
    endfunction

    assign rom_q0 = romf(2'd0, rom_addr0);
    assign rom_q1 = romf(2'd1, rom_addr1);
    assign rom_q2 = romf(2'd2, rom_addr2);
    assign rom_q3 = romf(2'd3, rom_addr3);

    rom_bank_arbiter #(.RESET_BANK(RB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_ack   (dbg_ack),
        .dbg_data  (dbg_data),
        .bank      (bank),
        .rom_addr0 (rom_addr0),
        .rom_addr1 (rom_addr1),
        .rom_addr2 (rom_addr2),
        .rom_addr3 (rom_addr3),
        .rom_q0    (rom_q0),
        .rom_q1    (rom_q1),
        .rom_q2    (rom_q2),
        .rom_q3    (rom_q3)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One CPU/debug cycle; w says the debug FSM is waiting for a grant.
    task automatic drive(input logic        v,
                         input logic [12:0] a,
                         input logic        rq,
                         input logic [13:0] da,
                         input logic        w);
        logic        cart;
        logic        g;
        logic [11:0] ex [4];
        @(negedge clk);
        cpu_valid = v;
        cpu_addr  = a;
        dbg_req   = rq;
        dbg_addr  = da;
        cart = v && a[12];
        g = w && (!cart || (da[13:12] != mb));
        for (int i = 0; i < 4; i++) ex[i] = 12'h000;
        if (cart) ex[mb] = a[11:0];
        if (g) ex[da[13:12]] = da[11:0];
        #1;
        chk("rom_addr0", rom_addr0, ex[0]);
        chk("rom_addr1", rom_addr1, ex[1]);
        chk("rom_addr2", rom_addr2, ex[2]);
        chk("rom_addr3", rom_addr3, ex[3]);
        sw_pend = 1'b0;
        if (cart) begin
            exq.push_back(romf(mb, a[11:0]));
`ifdef BANK_SWITCH_EN
            if (a[11:0] >= 12'hFF6 && a[11:0] <= 12'hFF9) begin
                logic [11:0] d;
                d = a[11:0] - 12'hFF6;
                sw_pend = 1'b1;
                sw_bank = d[1:0];
            end
`endif
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mb      = RB;
            last_rd = 8'h00;
        end else begin
            if (sw_pend) mb = sw_bank;
            chk("bank", bank, mb);
            if (exq.size() > 0) begin
                last_rd = exq.pop_front();
                chk("cpu_rvalid", cpu_rvalid, 1);
                chk("cpu_rdata", cpu_rdata, last_rd);
            end else begin
                chk("cpu_rvalid", cpu_rvalid, 0);
                chk("rdata_hold", cpu_rdata, last_rd);
            end
        end
    end

    logic        rv;
    logic [12:0] ra;
    logic [1:0]  m;
    logic [13:0] da;

    initial begin
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        dbg_req   = 1'b0;
        dbg_addr  = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_bank", bank, RB);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        chk("rst_ack", dbg_ack, 0);
        chk("rst_ddata", dbg_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive(1, 13'h1000, 0, 0, 0);
        drive(1, 13'h0234, 0, 0, 0);
        drive(0, 13'h1234, 0, 0, 0);
        drive(1, 13'h1FF8, 0, 0, 0);
        drive(1, 13'h1010, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = 13'($urandom);
            if (i % 4 == 3) ra[11:0] = 12'hFF6 + 12'($urandom_range(0, 3));
            drive(rv, ra, 0, 0, 0);
        end
        drive(1, 13'h1FF6, 0, 0, 0);
        drive(0, 13'h0000, 0, 0, 0);

        // Debug to the CPU's own bank waits out a cart stream.
        da = {mb, 12'h234};
        drive(1, 13'h1100, 1, da, 0);
        drive(1, 13'h1101, 1, da, 1);
        chk("conf_ack0", dbg_ack, 0);
        drive(1, 13'h1102, 0, da, 1);
        drive(1, 13'h1103, 0, da, 1);
        chk("conf_ack1", dbg_ack, 0);
        drive(0, 13'h0000, 0, da, 1);
        chk("conf_ack2", dbg_ack, 0);
        drive(1, 13'h1104, 0, da, 0);
        chk("conf_ack3", dbg_ack, 0);
        drive(0, 13'h0000, 0, da, 0);
        chk("conf_ack4", dbg_ack, 1);
        chk("conf_data", dbg_data, romf(da[13:12], 12'h234));
        drive(0, 13'h0000, 0, da, 0);
        chk("conf_ack5", dbg_ack, 0);

        // Debug to another bank runs in parallel with cart reads.
        m  = mb ^ 2'd3;
        da = {m, 12'hABC};
        drive(1, 13'h1200, 1, da, 0);
        drive(1, 13'h1201, 1, da, 1);
        chk("par_ack0", dbg_ack, 0);
        drive(1, 13'h1202, 1, da, 0);
        chk("par_ack1", dbg_ack, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 13'h1203 + 13'(i), (i < 2), da, 0);
            chk("par_ack_hold", dbg_ack, 1);
            chk("par_data", dbg_data, romf(m, 12'hABC));
        end
        drive(1, 13'h1206, 0, da, 0);
        chk("par_ack_drop", dbg_ack, 0);

        // Grant coincides with a CPU hotspot; debug hotspot offset is inert.
        m  = mb + 2'd2;
        da = {m, 12'hFF7};
        drive(1, 13'h1300, 1, da, 0);
        drive(1, {1'b1, 12'hFF6 + {10'd0, m}}, 1, da, 1);
        drive(0, 13'h0000, 1, da, 0);
        drive(0, 13'h0000, 0, da, 0);
        chk("hot_ack", dbg_ack, 1);
        chk("hot_data", dbg_data, romf(m, 12'hFF7));
        drive(0, 13'h0000, 0, da, 0);
        chk("hot_ack_drop", dbg_ack, 0);

        // Reset in the middle of a debug read abandons it.
        da = {mb ^ 2'd1, 12'h055};
        drive(0, 13'h0000, 1, da, 0);
        drive(0, 13'h0000, 1, da, 1);
        #2;
        rst_n   = 1'b0;
        sw_pend = 1'b0;
        dbg_req = 1'b0;
        exq.delete();
        #1;
        chk("mid_rst_ack", dbg_ack, 0);
        chk("mid_rst_ddata", dbg_data, 0);
        chk("mid_rst_bank", bank, RB);
        chk("mid_rst_rvalid", cpu_rvalid, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 13'h0000, 0, da, 0);
            chk("post_rst_ack", dbg_ack, 0);
        end
        drive(0, 13'h0000, 1, da, 0);
        drive(0, 13'h0000, 1, da, 1);
        drive(0, 13'h0000, 0, da, 0);
        drive(0, 13'h0000, 0, da, 0);
        chk("fresh_ack", dbg_ack, 1);
        chk("fresh_data", dbg_data, romf(da[13:12], 12'h055));
        drive(0, 13'h0000, 0, da, 0);
        chk("fresh_ack_drop", dbg_ack, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
